vane_adc_sequencer: RTL and testbench

//  Sequences the wind-vane SPI ADC: generates nVaneCS/SPICLK frames, shifts in a
//  16-bit MISO frame, and presents the extracted direction sample to the core

---
 rtl/vane_adc_sequencer_if.sv | 26 ++
 rtl/vane_adc_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vane_adc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vane_adc_sequencer_if.sv
// Sample handshake bundle between the vane ADC sequencer and its consumer.
// The sequencer drives the captured frame, the extracted direction field and
// the valid/overrun flags; the consumer answers with Sample_Ack.
interface vane_adc_sequencer_if;
  logic [15:0] Frame;
  logic [9:0]  Sample;
  logic        Sample_Valid;
  logic        Sample_Ack;
  logic        Overrun;

  modport master (
    output Frame,
    output Sample,
    output Sample_Valid,
    output Overrun,
    input  Sample_Ack
  );

  modport slave (
    input  Frame,
    input  Sample,
    input  Sample_Valid,
    input  Overrun,
    output Sample_Ack
  );
endinterface

// File: rtl/vane_adc_sequencer.sv
// Wind-vane SPI ADC sequencer. Runs one 16-bit read frame per conversion
// (chip select low for 33 half-periods, 16 SPICLK pulses, then a one
// half-period deselect gap) and hands the result to the core through a
// valid/ack handshake with a sticky overrun flag. Conversions start on a
// periodic timer (normal or demo period) or on an explicit Trigger; a request
// that arrives while busy is remembered in a single-entry pending flag.
module vane_adc_sequencer #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int DEMO_PERIOD   = 200,
  parameter int DATA_LSB      = 3
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic                        Demo,
  input  logic                        Trigger,
  input  logic                        MISO,
  output logic                        SPICLK,
  output logic                        nVaneCS,
  output logic                        Busy,
  vane_adc_sequencer_if.master        smp
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_MAX = (SAMPLE_PERIOD > DEMO_PERIOD) ? SAMPLE_PERIOD : DEMO_PERIOD;
  localparam int PER_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         half_q, half_d;
  logic [PER_W-1:0]   pcnt_q, pcnt_d;
  logic               pend_q, pend_d;
  logic               sclk_q, sclk_d;
  logic               ncs_q, ncs_d;
  logic               busy_q, busy_d;
  logic [15:0]        sr_q, sr_d;
  logic [15:0]        frame_q, frame_d;
  logic [9:0]         sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic               tick;
  logic               expired;
  logic               req;
  logic               start;
  logic               ack_take;
  logic [PER_W-1:0]   period_end;

  // Direction field sits at a fixed offset inside the raw ADC frame.
  function automatic logic [9:0] sample_field(input logic [15:0] f);
    return f[DATA_LSB +: 10];
  endfunction

  // Timer, request and handshake qualifiers shared by the next-state logic.
  always_comb begin
    period_end = Demo ? PER_W'(DEMO_PERIOD - 1) : PER_W'(SAMPLE_PERIOD - 1);
    expired    = Enable && (pcnt_q >= period_end);
    tick       = (state_q != IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
    req        = Trigger || pend_q || expired;
    // A queued request may restart straight out of the gap, so the gap end
    // counts as an idle slot for starting the next frame.
    start      = req && ((state_q == IDLE) || ((state_q == GAP) && tick));
    ack_take   = smp.Sample_Ack && valid_q;
  end

  // Frame sequencing, shift capture, result handshake, timer and pending flag.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    pcnt_d   = pcnt_q;
    pend_d   = pend_q;
    sclk_d   = sclk_q;
    ncs_d    = ncs_q;
    busy_d   = busy_q;
    sr_d     = sr_q;
    frame_d  = frame_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    // Half-period divider; half_q counts completed half-periods since E0.
    if (state_q != IDLE) begin
      if (tick) begin
        div_d  = '0;
        half_d = half_q + 6'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (ack_take) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!half_q[0]) begin
            sclk_d = 1'b0;
          end else begin
            // Rising SPICLK: capture MISO, MSB first.
            sclk_d = 1'b1;
            sr_d   = {sr_q[14:0], MISO};
            if (half_q == 6'd31) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ncs_d    = 1'b1;
          frame_d  = sr_q;
          sample_d = sample_field(sr_q);
          valid_d  = 1'b1;
          if (valid_q && !ack_take) ovr_d = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SETUP;
      div_d   = '0;
      half_d  = '0;
      pcnt_d  = '0;
      pend_d  = 1'b0;
      sclk_d  = 1'b1;
      ncs_d   = 1'b0;
      busy_d  = 1'b1;
    end else begin
      if (!Enable)       pcnt_d = '0;
      else if (!expired) pcnt_d = pcnt_q + PER_W'(1);
      if ((state_q != IDLE) && (Trigger || expired)) pend_d = 1'b1;
    end
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      half_q   <= '0;
      pcnt_q   <= '0;
      pend_q   <= 1'b0;
      sclk_q   <= 1'b1;
      ncs_q    <= 1'b1;
      busy_q   <= 1'b0;
      frame_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      pcnt_q   <= pcnt_d;
      pend_q   <= pend_d;
      sclk_q   <= sclk_d;
      ncs_q    <= ncs_d;
      busy_q   <= busy_d;
      frame_q  <= frame_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Shift register is fully rewritten by every frame, so it needs no reset.
  always_ff @(posedge Clock) begin
    sr_q <= sr_d;
  end

  assign SPICLK           = sclk_q;
  assign nVaneCS          = ncs_q;
  assign Busy             = busy_q;
  assign smp.Frame        = frame_q;
  assign smp.Sample       = sample_q;
  assign smp.Sample_Valid = valid_q;
  assign smp.Overrun      = ovr_q;

endmodule

// File: tb/tb_vane_adc_sequencer.sv
// Testbench for vane_adc_sequencer: an ADC model shifts queued words out on
// MISO, a frame monitor scores every completed frame against the expected
// queue, and a directed sequence walks trigger, periodic, overrun, pending,
// mid-frame reset and ack/completion-collision scenarios.
module tb_vane_adc_sequencer;

  logic Clock = 1'b0;
  logic Reset;
  logic Enable;
  logic Demo;
  logic Trigger;
  logic MISO;
  logic SPICLK;
  logic nVaneCS;
  logic Busy;

  vane_adc_sequencer_if smp();

  vane_adc_sequencer #(
    .CLK_DIV       (4),
    .SAMPLE_PERIOD (2000),
    .DEMO_PERIOD   (200),
    .DATA_LSB      (3)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .Demo    (Demo),
    .Trigger (Trigger),
    .MISO    (MISO),
    .SPICLK  (SPICLK),
    .nVaneCS (nVaneCS),
    .Busy    (Busy),
    .smp     (smp)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues: words the ADC will send, and frames expected back.
  logic [15:0] tx_q[$];
  logic [15:0] exp_q[$];
  int          e0_hist[$];

  task automatic queue_word(input logic [15:0] w);
    tx_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // ADC model: loads a word at chip-select fall, presents the next bit on
  // every SPICLK fall so it is stable at the following rise.
  logic [15:0] tx_word = 16'h0000;
  int          bit_idx = 15;
  always @(negedge nVaneCS) begin
    if (tx_q.size() > 0) tx_word = tx_q.pop_front();
    else                 tx_word = 16'h0000;
    bit_idx = 15;
  end
  always @(negedge SPICLK) begin
    if (bit_idx >= 0) begin
      MISO = tx_word[bit_idx];
      bit_idx--;
    end
  end

  // Frame monitor, sampled on the falling clock edge.
  logic ncs_prev = 1'b1;
  logic sclk_prev = 1'b1;
  int   e0_last = 0;
  int   sclk_rises = 0;
  int   done_cnt = 0;
  logic abort_pending = 1'b0;
  always @(negedge Clock) begin
    logic [15:0] w;
    if (ncs_prev === 1'b1 && nVaneCS === 1'b0) begin
      e0_hist.push_back(cyc);
      e0_last = cyc;
      sclk_rises = 0;
    end
    if (nVaneCS === 1'b0 && sclk_prev === 1'b0 && SPICLK === 1'b1) sclk_rises++;
    if (ncs_prev === 1'b0 && nVaneCS === 1'b1) begin
      if (abort_pending) begin
        abort_pending = 1'b0;
      end else begin
        chk("cs_low_cycles", cyc - e0_last, 132);
        chk("spiclk_pulses", sclk_rises, 16);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", exp_q.size(), 1);
        end else begin
          w = exp_q.pop_front();
          chk("frame", {16'h0, smp.Frame}, {16'h0, w});
          chk("sample", {22'h0, smp.Sample}, {22'h0, w[12:3]});
          chk("valid_at_done", {31'h0, smp.Sample_Valid}, 1);
        end
        done_cnt++;
      end
    end
    ncs_prev  = nVaneCS;
    sclk_prev = SPICLK;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse_trigger(output int edge_c);
    Trigger = 1'b1;
    step();
    Trigger = 1'b0;
    edge_c = cyc;
  endtask

  task automatic ack_pulse();
    smp.Sample_Ack = 1'b1;
    step();
    smp.Sample_Ack = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk({"done_", tag}, (done_cnt >= target) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    int t0;
    int t1;
    int base;
    int rel;

    Reset = 1'b1;
    Enable = 1'b0;
    Demo = 1'b0;
    Trigger = 1'b0;
    MISO = 1'b0;
    smp.Sample_Ack = 1'b0;
    repeat (3) step();

    chk("rst_spiclk", {31'h0, SPICLK}, 1);
    chk("rst_ncs", {31'h0, nVaneCS}, 1);
    chk("rst_busy", {31'h0, Busy}, 0);
    chk("rst_frame", {16'h0, smp.Frame}, 0);
    chk("rst_sample", {22'h0, smp.Sample}, 0);
    chk("rst_valid", {31'h0, smp.Sample_Valid}, 0);
    chk("rst_overrun", {31'h0, smp.Overrun}, 0);
    Reset = 1'b0;
    repeat (2) step();

    // Single triggered conversion.
    base = done_cnt;
    queue_word(16'hA5C3);
    pulse_trigger(t0);
    chk("t1_busy", {31'h0, Busy}, 1);
    wait_done(base + 1, 300, "t1");
    chk("t1_e0", e0_hist[$], t0);
    chk("t1_sample", {22'h0, smp.Sample}, 32'h0B8);
    chk("t1_overrun", {31'h0, smp.Overrun}, 0);
    ack_pulse();
    chk("t1_valid_cleared", {31'h0, smp.Sample_Valid}, 0);
    repeat (6) step();
    chk("t1_idle", {31'h0, Busy}, 0);

    // Periodic conversions in demo then normal mode.
    base = done_cnt;
    queue_word(16'h1234);
    queue_word(16'hFFFF);
    queue_word(16'h0000);
    queue_word(16'h8001);
    Demo = 1'b1;
    Enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_done(base + i, 400, "t2_demo");
      chk("t2_overrun", {31'h0, smp.Overrun}, 0);
      ack_pulse();
      chk("t2_valid_cleared", {31'h0, smp.Sample_Valid}, 0);
    end
    chk("t2_demo_spacing_a", e0_hist[$] - e0_hist[$-1], 200);
    chk("t2_demo_spacing_b", e0_hist[$-1] - e0_hist[$-2], 200);
    Demo = 1'b0;
    wait_done(base + 4, 2200, "t2_norm");
    Enable = 1'b0;
    chk("t2_norm_spacing", e0_hist[$] - e0_hist[$-1], 2000);
    chk("t2_overrun_final", {31'h0, smp.Overrun}, 0);
    ack_pulse();
    repeat (6) step();

    // Two unacked frames produce an overrun.
    base = done_cnt;
    queue_word(16'h0008);
    queue_word(16'h0010);
    pulse_trigger(t0);
    wait_done(base + 1, 300, "t3_a");
    pulse_trigger(t1);
    wait_done(base + 2, 300, "t3_b");
    chk("t3_sample", {22'h0, smp.Sample}, 32'h002);
    chk("t3_overrun", {31'h0, smp.Overrun}, 1);
    chk("t3_valid", {31'h0, smp.Sample_Valid}, 1);
    ack_pulse();
    chk("t3_valid_cleared", {31'h0, smp.Sample_Valid}, 0);
    chk("t3_overrun_cleared", {31'h0, smp.Overrun}, 0);
    repeat (6) step();

    // Requests while busy collapse into exactly one extra back-to-back frame.
    base = done_cnt;
    queue_word(16'h5A5A);
    queue_word(16'h0F0F);
    pulse_trigger(t0);
    wait_cyc(t0 + 39);
    pulse_trigger(t1);
    wait_cyc(t0 + 59);
    pulse_trigger(t1);
    wait_done(base + 2, 400, "t4");
    chk("t4_e0_prime", e0_hist[$] - t0, 136);
    repeat (300) step();
    chk("t4_frame_count", done_cnt - base, 2);
    chk("t4_idle", {31'h0, Busy}, 0);
    ack_pulse();
    repeat (4) step();

    // Reset in the middle of a frame, then first auto frame after release.
    base = done_cnt;
    queue_word(16'h7777);
    queue_word(16'h0ABC);
    Demo = 1'b0;
    Enable = 1'b1;
    abort_pending = 1'b1;
    pulse_trigger(t0);
    wait_cyc(t0 + 69);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    rel = cyc;
    void'(exp_q.pop_front());
    chk("t5_ncs", {31'h0, nVaneCS}, 1);
    chk("t5_spiclk", {31'h0, SPICLK}, 1);
    chk("t5_busy", {31'h0, Busy}, 0);
    chk("t5_frame", {16'h0, smp.Frame}, 0);
    chk("t5_valid", {31'h0, smp.Sample_Valid}, 0);
    repeat (140) step();
    chk("t5_no_valid", {31'h0, smp.Sample_Valid}, 0);
    wait_done(base + 1, 2300, "t5");
    Enable = 1'b0;
    chk("t5_auto_e0", e0_hist[$] - rel, 2000);
    repeat (6) step();

    // Completion in the same cycle as the ack of the previous sample.
    base = done_cnt;
    queue_word(16'h0C30);
    pulse_trigger(t0);
    wait_cyc(t0 + 131);
    chk("t6_valid_before", {31'h0, smp.Sample_Valid}, 1);
    ack_pulse();
    chk("t6_valid", {31'h0, smp.Sample_Valid}, 1);
    chk("t6_overrun", {31'h0, smp.Overrun}, 0);
    chk("t6_frame", {16'h0, smp.Frame}, 32'h0C30);
    wait_done(base + 1, 20, "t6");
    repeat (6) step();
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
